dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the MEM stage and a simple req/ack memory port.
// Handles byte/half/word alignment, lane replication for stores, sign/zero
// extension for loads, and a watchdog that aborts requests the memory never acks.
module dmem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [31:0] proc2Dmem_addr,
    input  logic [31:0] proc2Dmem_data,
    input  logic [1:0]  proc2Dmem_size,
    input  logic        proc2Dmem_unsigned,
    output logic [31:0] Dmem2proc_data,
    output logic        Dmem2proc_stall,
    output logic        Dmem2proc_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic        tout_q;
    logic [3:0]  be_q;
    logic [7:0]  cnt_q;

    logic        is_access;
    logic        misaligned;
    logic        accept;
    logic [31:0] wdata_d;
    logic [3:0]  be_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    // Request decode: command 3 behaves as no command, size 3 behaves as word.
    always_comb begin
        is_access = (proc2Dmem_command == BUS_LOAD) || (proc2Dmem_command == BUS_STORE);
        case (proc2Dmem_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = proc2Dmem_addr[0];
            default: misaligned = |proc2Dmem_addr[1:0];
        endcase
        accept = is_access && !misaligned;
    end

    // Store lane replication and byte enables; loads always enable the full word.
    always_comb begin
        wdata_d = '0;
        be_d    = 4'b1111;
        if (proc2Dmem_command == BUS_STORE) begin
            case (proc2Dmem_size)
                2'd0: begin
                    wdata_d = {4{proc2Dmem_data[7:0]}};
                    be_d    = 4'b0001 << proc2Dmem_addr[1:0];
                end
                2'd1: begin
                    wdata_d = {2{proc2Dmem_data[15:0]}};
                    be_d    = proc2Dmem_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_d = proc2Dmem_data;
                    be_d    = 4'b1111;
                end
            endcase
        end
    end

    // Load lane extraction from the captured word, then sign/zero extension.
    always_comb begin
        ld_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    load_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = rdata_q;
        endcase
    end

    // Sequencer: latch the request, wait for ack or watchdog expiry, present one response cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            tout_q  <= 1'b0;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= proc2Dmem_addr;
                        size_q  <= proc2Dmem_size;
                        uns_q   <= proc2Dmem_unsigned;
                        we_q    <= (proc2Dmem_command == BUS_STORE);
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        rdata_q <= '0;
                        tout_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the final watchdog cycle still counts as a completion.
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'h0 : mem_rdata;
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        tout_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs gated by state so idle and reset present an all-zero memory port;
    // stall/error also gated by rst so an asserted reset silences them immediately.
    always_comb begin
        mem_req         = (state_q == REQ);
        mem_we          = mem_req && we_q;
        mem_addr        = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata       = mem_req ? wdata_q : 32'h0;
        mem_be          = mem_req ? be_q : 4'h0;
        Dmem2proc_stall = rst && (((state_q == IDLE) && accept) || (state_q == REQ));
        Dmem2proc_error = rst && (((state_q == IDLE) && is_access && misaligned)
                                  || ((state_q == RESP) && tout_q));
        Dmem2proc_data  = ((state_q == RESP) && !we_q) ? load_ext : 32'h0;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: table of accesses driven one after another, per-cycle
// checks of the memory port, and a response scoreboard popped on each response.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  proc2Dmem_command;
    logic [31:0] proc2Dmem_addr;
    logic [31:0] proc2Dmem_data;
    logic [1:0]  proc2Dmem_size;
    logic        proc2Dmem_unsigned;
    logic [31:0] Dmem2proc_data;
    logic        Dmem2proc_stall;
    logic        Dmem2proc_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .proc2Dmem_size     (proc2Dmem_size),
        .proc2Dmem_unsigned (proc2Dmem_unsigned),
        .Dmem2proc_data     (Dmem2proc_data),
        .Dmem2proc_stall    (Dmem2proc_stall),
        .Dmem2proc_error    (Dmem2proc_error),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_be             (mem_be),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        uns;
        int          ack_dly;
        logic [31:0] rdata;
        bit          b2b;
        int          exp_req;
        int          exp_stall;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    vec_t  vecs[$];
    int    checks = 0;
    int    errors = 0;
    bit    prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Response monitor: a response is a non-stall cycle that follows a stall,
    // or an immediate error cycle for a misaligned request.
    always @(negedge clk) begin
        resp_t r;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (!Dmem2proc_stall && (prev_stall || Dmem2proc_error)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response data=%h error=%b", Dmem2proc_data, Dmem2proc_error);
                end else begin
                    r = sb_q.pop_front();
                    check("resp_data", Dmem2proc_data, r.data);
                    check("resp_error", {31'b0, Dmem2proc_error}, {31'b0, r.err});
                end
            end
            prev_stall = Dmem2proc_stall;
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int  seen;
        int  req_cyc;
        int  stall_cyc;
        int  err_cyc;
        bit  done;
        resp_t r;
        seen = 0; req_cyc = 0; stall_cyc = 0; err_cyc = 0; done = 1'b0;
        @(posedge clk); #1;
        proc2Dmem_command  = v.cmd;
        proc2Dmem_addr     = v.addr;
        proc2Dmem_data     = v.data;
        proc2Dmem_size     = v.size;
        proc2Dmem_unsigned = v.uns;
        if (v.exp_req > 0 || v.exp_err) begin
            r.data = v.exp_data;
            r.err  = v.exp_err;
            sb_q.push_back(r);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            if (mem_req) begin
                seen++;
                if (seen == v.ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            @(negedge clk);
            if (Dmem2proc_stall) stall_cyc++;
            if (Dmem2proc_error) err_cyc++;
            if (mem_req) begin
                req_cyc++;
                check($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
                check($sformatf("v%0d_mem_we", idx), {31'b0, mem_we}, {31'b0, v.exp_we});
                check($sformatf("v%0d_mem_be", idx), {28'b0, mem_be}, {28'b0, v.exp_be});
                if (v.exp_we) check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
            end
            if (!Dmem2proc_stall) begin
                done = 1'b1;
                break;
            end
        end
        mem_ack = 1'b0;
        check($sformatf("v%0d_done", idx), {31'b0, done}, 32'd1);
        check($sformatf("v%0d_req_cycles", idx), req_cyc, v.exp_req);
        check($sformatf("v%0d_stall_cycles", idx), stall_cyc, v.exp_stall);
        check($sformatf("v%0d_err_cycles", idx), err_cyc, v.exp_err ? 32'd1 : 32'd0);
        if (!v.b2b) begin
            @(posedge clk); #1;
            proc2Dmem_command = 2'd0;
            @(negedge clk);
            check($sformatf("v%0d_idle_after", idx),
                  {Dmem2proc_stall, Dmem2proc_error, mem_req, 29'b0} | Dmem2proc_data, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        //          cmd   addr          data          sz  u ack rdata         b2b req st we addr          wdata         be       data          err
        vecs.push_back('{2'd1, 32'h0000_0100, 32'h0,        2'd2, 0, 3, 32'hDEAD_BEEF, 0, 3, 4, 0, 32'h0000_0100, 32'h0,        4'b1111, 32'hDEAD_BEEF, 0});
        vecs.push_back('{2'd1, 32'h0000_0103, 32'h0,        2'd0, 0, 1, 32'h80FF_1234, 0, 1, 2, 0, 32'h0000_0100, 32'h0,        4'b1111, 32'hFFFF_FF80, 0});
        vecs.push_back('{2'd1, 32'h0000_0103, 32'h0,        2'd0, 1, 1, 32'h80FF_1234, 0, 1, 2, 0, 32'h0000_0100, 32'h0,        4'b1111, 32'h0000_0080, 0});
        vecs.push_back('{2'd2, 32'h0000_0202, 32'h0000_ABCD, 2'd1, 0, 2, 32'h1234_5678, 0, 2, 3, 1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'h0,         0});
        vecs.push_back('{2'd1, 32'h0000_0101, 32'h0,        2'd2, 0, 1, 32'h1111_1111, 0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 32'h0,         1});
        vecs.push_back('{2'd1, 32'h0000_0300, 32'h0,        2'd2, 0, 0, 32'h0,         0, 4, 5, 0, 32'h0000_0300, 32'h0,        4'b1111, 32'h0,         1});
        vecs.push_back('{2'd2, 32'h0000_0301, 32'h1234_56A5, 2'd0, 0, 1, 32'h5555_5555, 0, 1, 2, 1, 32'h0000_0300, 32'hA5A5_A5A5, 4'b0010, 32'h0,         0});
        vecs.push_back('{2'd1, 32'h0000_0402, 32'h0,        2'd1, 0, 2, 32'h8001_7FFF, 0, 2, 3, 0, 32'h0000_0400, 32'h0,        4'b1111, 32'hFFFF_8001, 0});
        vecs.push_back('{2'd1, 32'h0000_0400, 32'h0,        2'd1, 1, 1, 32'h8001_F00F, 0, 1, 2, 0, 32'h0000_0400, 32'h0,        4'b1111, 32'h0000_F00F, 0});
        vecs.push_back('{2'd2, 32'h0000_0203, 32'h0000_1234, 2'd1, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 32'h0,         1});
        vecs.push_back('{2'd2, 32'h0000_0010, 32'hCAFE_F00D, 2'd2, 0, 1, 32'h0,         1, 1, 2, 1, 32'h0000_0010, 32'hCAFE_F00D, 4'b1111, 32'h0,         0});
        vecs.push_back('{2'd1, 32'h0000_0014, 32'h0,        2'd3, 0, 1, 32'h0123_4567, 0, 1, 2, 0, 32'h0000_0014, 32'h0,        4'b1111, 32'h0123_4567, 0});
        vecs.push_back('{2'd3, 32'h0000_0100, 32'h0,        2'd2, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 32'h0,         0});
        vecs.push_back('{2'd1, 32'h0000_0101, 32'h0,        2'd0, 1, 1, 32'h0000_9A00, 0, 1, 2, 0, 32'h0000_0100, 32'h0,        4'b1111, 32'h0000_009A, 0});
        vecs.push_back('{2'd2, 32'h0000_0103, 32'h0000_0077, 2'd0, 0, 4, 32'h0,         0, 4, 5, 1, 32'h0000_0100, 32'h7777_7777, 4'b1000, 32'h0,         0});

        rst                = 1'b0;
        proc2Dmem_command  = 2'd1;
        proc2Dmem_addr     = 32'h0000_0100;
        proc2Dmem_data     = 32'h0;
        proc2Dmem_size     = 2'd2;
        proc2Dmem_unsigned = 1'b0;
        mem_ack            = 1'b0;
        mem_rdata          = 32'h0;

        // Reset with a valid LOAD on the inputs: every output must stay zero.
        repeat (3) @(negedge clk);
        check("rst_stall", {31'b0, Dmem2proc_stall}, 32'h0);
        check("rst_error", {31'b0, Dmem2proc_error}, 32'h0);
        check("rst_data", Dmem2proc_data, 32'h0);
        check("rst_mem_port", {mem_req, mem_we, 26'b0, mem_be}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        proc2Dmem_command = 2'd0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'b0, Dmem2proc_stall | mem_req}, 32'h0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset asserted mid-request drops the memory port and stall at once.
        @(posedge clk); #1;
        proc2Dmem_command = 2'd1;
        proc2Dmem_addr    = 32'h0000_0500;
        proc2Dmem_size    = 2'd2;
        @(posedge clk); #1;
        check("midrst_req_before", {31'b0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_req_drop", {31'b0, mem_req}, 32'h0);
        check("midrst_stall_drop", {31'b0, Dmem2proc_stall}, 32'h0);
        check("midrst_addr_drop", mem_addr, 32'h0);
        @(posedge clk); #1;
        proc2Dmem_command = 2'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_resp", {Dmem2proc_stall, Dmem2proc_error, mem_req, 29'b0} | Dmem2proc_data, 32'h0);
        end
        check("midrst_sb_empty", sb_q.size(), 32'd0);
        run_vec('{2'd1, 32'h0000_0500, 32'h0, 2'd2, 1'b0, 2, 32'h5A5A_0F0F, 1'b0, 2, 3, 1'b0,
                  32'h0000_0500, 32'h0, 4'b1111, 32'h5A5A_0F0F, 1'b0}, 99);

        repeat (2) @(negedge clk);
        check("final_sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
